i2c_bus_conditioner: RTL
========================

Name: i2c_bus_conditioner

Overview:
- Front-end stage directly upstream of i2c_slave.
- Takes raw asynchronous SCL/SDA pins, synchronises and glitch-filters them.
- Produces clean levels, one-cycle edge strobes, START/repeated-START/STOP events and a bus-busy flag.
- i2c_slave consumes the filtered levels and strobes instead of sampling the raw bus.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per line (legal 2..4).
- FILTER_LEN, 4, consecutive stable cycles required before a filtered level changes (legal 1..15).
- TIMEOUT_CYCLES, 1000, SCL-low cycles before bus timeout (used only with I2C_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- scl_in  input  1  raw SCL pin level, asynchronous.
- sda_in  input  1  raw SDA pin level, asynchronous.
- scl_filt  output  1  synchronised, filtered SCL.
- sda_filt  output  1  synchronised, filtered SDA.
- scl_rise  output  1  one-cycle pulse: scl_filt went 0->1.
- scl_fall  output  1  one-cycle pulse: scl_filt went 1->0.
- start_det  output  1  one-cycle pulse: START seen while bus idle.
- repstart_det  output  1  one-cycle pulse: START seen while bus busy.
- stop_det  output  1  one-cycle pulse: STOP seen.
- bus_busy  output  1  high between START and STOP.
- timeout  output  1  one-cycle pulse: SCL held low too long. Constant 0 without I2C_TIMEOUT_EN.

Behaviour:
- Reset, async, active-high:
  - Synchroniser flops and scl_filt/sda_filt = 1 (idle bus).
  - Filter counters = 0.
  - All pulse outputs = 0, bus_busy = 0, FSM = IDLE.
- Synchroniser: SYNC_STAGES-deep flop chain per line.
- Filter, per line:
  - Counter increments while the synced level differs from the filtered level.
  - Counter clears whenever the two are equal.
  - When the counter reaches FILTER_LEN, the filtered level toggles and the counter clears.
  - Any glitch shorter than FILTER_LEN cycles is discarded.
- Latency: a clean pin transition appears on the *_filt output SYNC_STAGES+FILTER_LEN rising edges later (6 at defaults).
- Edge strobes are registered. They assert in the same cycle the filtered level first shows its new value, for exactly 1 cycle.
- Event decode uses the previous and current filtered values:
  - START = sda_filt falls while scl_filt is 1 in both the previous and current cycle.
  - STOP = sda_filt rises under the same SCL condition.
  - If scl_filt and sda_filt change in the same cycle, no START/STOP is reported; this counts as an ordinary data change.
- FSM, 2 states:
  - IDLE: START -> start_det=1, go BUSY. STOP -> stop_det=1, stay IDLE (stray STOP is reported).
  - BUSY: START -> repstart_det=1 (start_det stays 0), stay BUSY. STOP -> stop_det=1, go IDLE.
- bus_busy is the registered state (BUSY=1). It rises the cycle after start_det and falls the cycle after stop_det.
- At most one of start_det/repstart_det/stop_det is high in any cycle.
- Reset mid-transfer: immediate return to IDLE, all outputs to reset values, no stop_det generated.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) counts cycles with scl_filt=0 while BUSY. It clears on scl_filt=1 and in IDLE.
  - On reaching TIMEOUT_CYCLES: timeout=1 for one cycle, FSM forced to IDLE (bus_busy=0 next cycle), counter cleared.
  - A timeout coinciding with a START/STOP event: the timeout wins and the event pulse is suppressed.
- Undefined: counter logic absent, timeout tied to 0.

Decomposition:
- Shared package i2c_pkg:
  - FSM state encodings (I2C_BUS_IDLE, I2C_BUS_BUSY).
  - Idle line level constant (1).
  - Filter-counter width constant (4 bits).
- Natural sub-module: i2c_glitch_filter (synchroniser + filter for one line, parameters SYNC_STAGES/FILTER_LEN, outputs level plus rise/fall strobes). Instantiated twice.

Test Plan (defaults):
- Reset asserted mid-stream -> scl_filt=sda_filt=1, all pulses 0, bus_busy=0 asynchronously. Release -> no spurious pulses for 20 cycles with pins high.
- scl_in=1, sda_in pulsed low for 3 cycles -> sda_filt stays 1, no start_det. Low for 4 cycles -> sda_filt falls at edge 6 and start_det pulses once.
- START, then 8 SCL clocks (20-cycle half-periods) -> exactly 8 scl_rise and 8 scl_fall pulses, bus_busy=1 throughout, no events during SDA changes while SCL low.
- While busy, SDA 0->1 with SCL low, SCL rises, SDA falls -> repstart_det=1 for one cycle, start_det=0, bus_busy stays 1.
- SDA 0->1 with SCL high -> stop_det one cycle, bus_busy=0 next cycle. scl_in and sda_in toggled on the same clock -> neither event.
- With I2C_TIMEOUT_EN, TIMEOUT_CYCLES=50: START then SCL held low -> timeout pulses at SCL-low cycle 50, bus_busy drops. Without the macro, timeout remains 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus front-end: bus FSM states, idle line level
// and the glitch-filter counter width.
package i2c_pkg;

   typedef enum logic {
      I2C_BUS_IDLE = 1'b0,
      I2C_BUS_BUSY = 1'b1
   } i2c_bus_state_e;

   localparam logic I2C_IDLE_LEVEL = 1'b1;
   localparam int   I2C_FILT_CNT_W = 4;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: SYNC_STAGES-deep synchroniser followed by a FILTER_LEN-cycle
// stability filter, with registered one-cycle rise/fall strobes.
module i2c_glitch_filter
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [I2C_FILT_CNT_W-1:0] CNT_LAST = I2C_FILT_CNT_W'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0]    sync_q;
   logic [I2C_FILT_CNT_W-1:0] cnt_q;
   logic                      synced;
   logic                      differs;
   logic                      toggle;

   assign synced  = sync_q[SYNC_STAGES-1];
   assign differs = (synced != level);
   assign toggle  = differs && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      end
   end

   // The level only moves after FILTER_LEN consecutive disagreeing samples;
   // strobes are registered alongside so they line up with the new level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level <= I2C_IDLE_LEVEL;
         cnt_q <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else if (toggle) begin
         level <= ~level;
         cnt_q <= '0;
         rise  <= ~level;
         fall  <= level;
      end else begin
         rise  <= 1'b0;
         fall  <= 1'b0;
         cnt_q <= differs ? cnt_q + 1'b1 : '0;
      end
   end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Conditions raw SCL/SDA for i2c_slave: filtered levels, edge strobes, START /
// repeated-START / STOP decode and bus-busy. Bus timeout is built only with I2C_TIMEOUT_EN.
module i2c_bus_conditioner
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_filt,
   output logic sda_filt,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic repstart_det,
   output logic stop_det,
   output logic bus_busy,
   output logic timeout
);

   logic           sda_rise;
   logic           sda_fall;
   logic           scl_steady_high;
   logic           start_cond;
   logic           stop_cond;
   logic           to_hit;
   i2c_bus_state_e state_q;
   i2c_bus_state_e state_d;

   i2c_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_scl_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (scl_in),
      .level   (scl_filt),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sda_filter (
      .clk     (clk),
      .reset   (reset),
      .line_in (sda_in),
      .level   (sda_filt),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   // SCL high now and no rise strobe means it was high last cycle as well.
   assign scl_steady_high = scl_filt && !scl_rise;
   assign start_cond      = sda_fall && scl_steady_high;
   assign stop_cond       = sda_rise && scl_steady_high;

`ifdef I2C_TIMEOUT_EN
   localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q;

   assign to_hit = (state_q == I2C_BUS_BUSY) && !scl_filt && (to_cnt_q == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if ((state_q != I2C_BUS_BUSY) || scl_filt || to_hit) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   // No timeout hardware; the parameter is referenced only to keep the tie-off explicit.
   assign to_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= I2C_BUS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (to_hit) begin
         state_d = I2C_BUS_IDLE;
      end else begin
         case (state_q)
            I2C_BUS_IDLE: if (start_cond) state_d = I2C_BUS_BUSY;
            I2C_BUS_BUSY: if (stop_cond)  state_d = I2C_BUS_IDLE;
            default:      state_d = I2C_BUS_IDLE;
         endcase
      end
   end

   // A timeout takes priority and masks any coincident bus event.
   always_comb begin
      start_det    = 1'b0;
      repstart_det = 1'b0;
      stop_det     = 1'b0;
      bus_busy     = (state_q == I2C_BUS_BUSY);
      timeout      = to_hit;
      if (!to_hit) begin
         start_det    = start_cond && (state_q == I2C_BUS_IDLE);
         repstart_det = start_cond && (state_q == I2C_BUS_BUSY);
         stop_det     = stop_cond;
      end
   end

endmodule
